// File: rtl/rr_bus_arbiter4.sv
// rr_bus_arbiter4
//   Round-robin arbiter that shares one WIDTH-bit bus between four
//   requesters. A registered two-state FSM owns the mux select and the
//   one-hot grant. Each grant is limited to MAX_BURST accepted beats.
//   out_ready from the consumer provides backpressure.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no owner, gnt=0; picks next requester after 'last'
//   BUSY  | owner=sel holds the bus until req drops or burst completes
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester bus request, held while data is pending
//   data_a..d  requester 0..3 data
//   out_ready  consumer accepts a beat this cycle
//   gnt        registered one-hot grant (zero when idle)
//   sel        registered owner index driving the data mux
//   out_data   data of the selected requester
//   out_valid  owner is granted and still requesting
//   busy       FSM is in BUSY
module rr_bus_arbiter4 #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    logic [0:0] state;
    logic [7:0] beat_cnt;
    logic [1:0] last;
    logic [1:0] winner;
    logic       beat;

    // Scan from farthest to nearest so the first set request after 'last'
    // is the one left standing.
    always_comb begin
        logic [1:0] cand;
        winner = last;
        cand   = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    out_data = data_a;
            2'd1:    out_data = data_b;
            2'd2:    out_data = data_c;
            default: out_data = data_d;
        endcase
    end

    assign out_valid = gnt[sel] & req[sel];
    assign beat      = out_valid & out_ready;
    assign busy      = (state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            beat_cnt <= 8'd0;
            last     <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 4'b0000) begin
                        state    <= ST_BUSY;
                        sel      <= winner;
                        gnt      <= 4'b0001 << winner;
                        beat_cnt <= 8'd0;
                    end
                end
                default: begin
                    if (!req[sel]) begin
                        // Owner withdrew: release without counting a beat.
                        state    <= ST_IDLE;
                        gnt      <= 4'b0000;
                        last     <= sel;
                        beat_cnt <= 8'd0;
                    end else if (beat) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= ST_IDLE;
                            gnt      <= 4'b0000;
                            last     <= sel;
                            beat_cnt <= 8'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Testbench for rr_bus_arbiter4: two instances (MAX_BURST=4 and 1) share
// stimulus; each is compared every cycle against a transaction-level model.
module tb_rr_bus_arbiter4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [15:0] data_a = 16'h0, data_b = 16'h0, data_c = 16'h0, data_d = 16'h0;
    logic        out_ready = 1'b0;

    logic [3:0]  gnt4, gnt1;
    logic [1:0]  sel4, sel1;
    logic [15:0] od4, od1;
    logic        ov4, ov1, busy4, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner (-1 = nobody), beats accepted in this grant, last owner.
    int own[2];
    int bts[2];
    int lst[2];
    int mb[2];

    always #5 clk = ~clk;

    rr_bus_arbiter4 #(.WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .out_ready(out_ready), .gnt(gnt4), .sel(sel4), .out_data(od4),
        .out_valid(ov4), .busy(busy4)
    );

    rr_bus_arbiter4 #(.WIDTH(16), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .out_ready(out_ready), .gnt(gnt1), .sel(sel1), .out_data(od1),
        .out_valid(ov1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [15:0] data_of(input int i);
        case (i)
            0:       return data_a;
            1:       return data_b;
            2:       return data_c;
            default: return data_d;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = -1;
            bts[m] = 0;
            lst[m] = 3;
        end
    endtask

    task automatic compare_all();
        logic [3:0]  g [2];
        logic [1:0]  s [2];
        logic [15:0] d [2];
        logic        v [2];
        logic        b [2];
        g[0] = gnt4; s[0] = sel4; d[0] = od4; v[0] = ov4; b[0] = busy4;
        g[1] = gnt1; s[1] = sel1; d[1] = od1; v[1] = ov1; b[1] = busy1;
        for (int m = 0; m < 2; m++) begin
            string sfx;
            sfx = (m == 0) ? "_b4" : "_b1";
            if (own[m] < 0) begin
                chk({"gnt", sfx}, 32'(g[m]), 32'd0);
                chk({"valid", sfx}, 32'(v[m]), 32'd0);
                chk({"busy", sfx}, 32'(b[m]), 32'd0);
            end else begin
                chk({"gnt", sfx}, 32'(g[m]), 32'(1 << own[m]));
                chk({"sel", sfx}, 32'(s[m]), 32'(own[m]));
                chk({"data", sfx}, 32'(d[m]), 32'(data_of(own[m])));
                chk({"valid", sfx}, 32'(v[m]), 32'(req[own[m]]));
                chk({"busy", sfx}, 32'(b[m]), 32'd1);
            end
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (own[m] < 0) begin
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (req[(lst[m] + k) % 4]) begin
                            own[m] = (lst[m] + k) % 4;
                            bts[m] = 0;
                            break;
                        end
                    end
                end
            end else if (!req[own[m]]) begin
                lst[m] = own[m];
                own[m] = -1;
            end else if (out_ready) begin
                bts[m]++;
                if (bts[m] == mb[m]) begin
                    lst[m] = own[m];
                    own[m] = -1;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check shortly after, advance model at posedge.
    task automatic cycle(input logic [3:0] r, input logic rdy);
        @(negedge clk);
        req = r;
        out_ready = rdy;
        #1;
        compare_all();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt4), 32'd0);
        chk("rst_valid", 32'(ov4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_gnt_b1", 32'(gnt1), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        mb[0] = 4;
        mb[1] = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("por_gnt", 32'(gnt4), 32'd0);

        // Mid-burst reset while requester 1 owns the bus.
        data_a = 16'h1111; data_b = 16'h2222; data_c = 16'h3333; data_d = 16'h4444;
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_gnt", 32'(gnt4), 32'b0010);
        do_reset();
        cycle(4'b1111, 1'b1);
        @(negedge clk);
        #1;
        chk("post_rst_first_gnt", 32'(gnt4), 32'b0001);
        do_reset();

        // Single requester regranted after its burst.
        data_c = 16'hBEEF;
        repeat (14) cycle(4'b0100, 1'b1);

        // All requesting: rotating order.
        do_reset();
        repeat (30) cycle(4'b1111, 1'b1);

        // Backpressure on owner 1 after two beats.
        do_reset();
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        repeat (3) cycle(4'b0010, 1'b0);
        repeat (4) cycle(4'b0010, 1'b1);

        // Owner 3 drops early; next grant with 0 and 3 requesting goes to 0.
        do_reset();
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        repeat (4) cycle(4'b1001, 1'b1);

        // Two requesters, exercises MAX_BURST=1 alternation.
        do_reset();
        repeat (12) cycle(4'b0011, 1'b1);

        // Random traffic, requests held mostly stable.
        do_reset();
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 2000; i++) begin
                data_a = 16'($urandom); data_b = 16'($urandom);
                data_c = 16'($urandom); data_d = 16'($urandom);
                if ($urandom_range(0, 3) == 0) r = 4'($urandom);
                cycle(r, ($urandom_range(0, 3) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
